// File: rtl/tdc_hit_buffer.sv
// Multi-entry TDC capture buffer: en-strobed words go into a first-word-fall-through
// FIFO with a registered head word, plus occupancy, sticky overflow and a saturating drop count.
module tdc_hit_buffer #(
    parameter int WIDTH = 42,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [WIDTH-1:0]         Din,
    input  logic                     flush,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         Q,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic [CNTW-1:0]          drop_cnt,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [CNTW-1:0] DROP_ONE = CNTW'(1);

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + DROP_ONE;
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    rptr_n;
    logic [AW:0]      count_n;
    logic [WIDTH-1:0] q_n;
    logic             push;
    logic             pop;
    logic             drop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign rd_valid = ~empty;

    // Handshake decisions; flush suppresses both sides of the FIFO for its cycle.
    always_comb begin
        pop  = rd_valid & rd_ready & ~flush;
        push = en & (~full | pop) & ~flush;
        drop = en & full & ~pop & ~flush;
    end

    always_comb begin
        rptr_n  = pop ? rptr + PTR_ONE : rptr;
        count_n = count;
        unique case ({push, pop})
            2'b10:   count_n = count + CNT_ONE;
            2'b01:   count_n = count - CNT_ONE;
            default: count_n = count;
        endcase
        if (flush) begin
            count_n = '0;
        end

        // The head register must already hold the word that will sit at rptr_n.
        // If the FIFO is (or is about to become) empty, that word is the one arriving now.
        q_n = Q;
        if (!flush && count_n != '0) begin
            if (count == '0 || (count == CNT_ONE && pop)) begin
                q_n = Din;
            end else begin
                q_n = mem[rptr_n];
            end
        end
    end

    // Storage array: data only, never reset.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wptr] <= Din;
        end
    end

    // Control state and registered head word.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            Q     <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            rptr  <= rptr_n;
            count <= count_n;
            Q     <= q_n;
        end
    end

    // A drop in the same cycle as clr_ovf restarts the count at one.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf      <= 1'b1;
            drop_cnt <= clr_ovf ? DROP_ONE : sat_inc(drop_cnt);
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_tdc_hit_buffer.sv
// Bench for tdc_hit_buffer: constant vector table for the basic scenarios, a queue
// scoreboard for word order, and hand-written sequences for saturation, wrap and reset.
module tb_tdc_hit_buffer;

    localparam int W = 42;
    localparam int D = 4;
    localparam int C = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          en = 1'b0;
    logic [W-1:0]  Din = '0;
    logic          flush = 1'b0;
    logic          rd_ready = 1'b0;
    logic          clr_ovf = 1'b0;
    logic          rd_valid;
    logic [W-1:0]  Q;
    logic [2:0]    count;
    logic          full;
    logic          empty;
    logic          ovf;
    logic [C-1:0]  drop_cnt;

    tdc_hit_buffer #(.WIDTH(W), .DEPTH(D), .CNTW(C)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .Din      (Din),
        .flush    (flush),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .Q        (Q),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf      (ovf),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] sb [$];
    logic [W-1:0] m_q = '0;
    logic         m_ovf = 1'b0;
    logic [C-1:0] m_drop = '0;

    typedef struct {
        logic         rst;
        logic         en;
        logic [W-1:0] din;
        logic         rdy;
        logic         fl;
        logic         clr;
        logic [2:0]   cnt;
        logic         vld;
        logic [W-1:0] q;
        logic         ovf;
        logic [C-1:0] drp;
    } vec_t;

    vec_t tbl [28];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [W-1:0] d,
                                input logic rd, input logic f, input logic cl,
                                input logic [2:0] cn, input logic v, input logic [W-1:0] q,
                                input logic o, input logic [C-1:0] dr);
        vec_t t;
        t.rst = r; t.en = e; t.din = d; t.rdy = rd; t.fl = f; t.clr = cl;
        t.cnt = cn; t.vld = v; t.q = q; t.ovf = o; t.drp = dr;
        return t;
    endfunction

    // One clock: drive inputs, predict with the scoreboard, then check all outputs after the edge.
    task automatic cycle(input logic r, input logic e, input logic [W-1:0] d,
                         input logic rd, input logic f, input logic cl);
        logic pop_m, full_m, push_m, drop_m;
        reset = r; en = e; Din = d; rd_ready = rd; flush = f; clr_ovf = cl;
        full_m = (sb.size() == D);
        pop_m  = !r && !f && rd && (sb.size() > 0);
        push_m = !r && !f && e && (!full_m || pop_m);
        drop_m = !r && !f && e && full_m && !pop_m;
        if (pop_m) begin
            chk("head_on_pop", 64'(Q), 64'(sb[0]));
            void'(sb.pop_front());
        end
        if (push_m) sb.push_back(d);
        if (r) begin
            sb.delete();
            m_q = '0;
            m_ovf = 1'b0;
            m_drop = '0;
        end else begin
            if (f) sb.delete();
            if (drop_m) begin
                m_ovf = 1'b1;
                m_drop = cl ? C'(1) : ((m_drop == {C{1'b1}}) ? m_drop : m_drop + C'(1));
            end else if (cl) begin
                m_ovf = 1'b0;
                m_drop = '0;
            end
            if (sb.size() > 0) m_q = sb[0];
        end
        @(posedge clk);
        #1;
        chk("count", 64'(count), 64'(sb.size()));
        chk("rd_valid", 64'(rd_valid), 64'(sb.size() > 0));
        chk("empty", 64'(empty), 64'(sb.size() == 0));
        chk("full", 64'(full), 64'(sb.size() == D));
        chk("q", 64'(Q), 64'(m_q));
        chk("ovf", 64'(ovf), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    endtask

    initial begin
        // reset, single capture
        tbl[0]  = mk(1, 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);
        tbl[1]  = mk(1, 0, '0, 0, 0, 0, 0, 0, '0, 0, 0);
        tbl[2]  = mk(0, 1, 42'h2AB_CDEF_0123, 0, 0, 0, 1, 1, 42'h2AB_CDEF_0123, 0, 0);
        tbl[3]  = mk(0, 0, '0, 1, 0, 0, 0, 0, 42'h2AB_CDEF_0123, 0, 0);
        // fill and overflow, then drain
        tbl[4]  = mk(0, 1, 42'd1, 0, 0, 0, 1, 1, 42'd1, 0, 0);
        tbl[5]  = mk(0, 1, 42'd2, 0, 0, 0, 2, 1, 42'd1, 0, 0);
        tbl[6]  = mk(0, 1, 42'd3, 0, 0, 0, 3, 1, 42'd1, 0, 0);
        tbl[7]  = mk(0, 1, 42'd4, 0, 0, 0, 4, 1, 42'd1, 0, 0);
        tbl[8]  = mk(0, 1, 42'd5, 0, 0, 0, 4, 1, 42'd1, 1, 1);
        tbl[9]  = mk(0, 1, 42'd6, 0, 0, 0, 4, 1, 42'd1, 1, 2);
        tbl[10] = mk(0, 0, '0, 1, 0, 0, 3, 1, 42'd2, 1, 2);
        tbl[11] = mk(0, 0, '0, 1, 0, 0, 2, 1, 42'd3, 1, 2);
        tbl[12] = mk(0, 0, '0, 1, 0, 0, 1, 1, 42'd4, 1, 2);
        tbl[13] = mk(0, 0, '0, 1, 0, 0, 0, 0, 42'd4, 1, 2);
        // full with simultaneous pop
        tbl[14] = mk(0, 1, 42'd1, 0, 0, 0, 1, 1, 42'd1, 1, 2);
        tbl[15] = mk(0, 1, 42'd2, 0, 0, 0, 2, 1, 42'd1, 1, 2);
        tbl[16] = mk(0, 1, 42'd3, 0, 0, 0, 3, 1, 42'd1, 1, 2);
        tbl[17] = mk(0, 1, 42'd4, 0, 0, 0, 4, 1, 42'd1, 1, 2);
        tbl[18] = mk(0, 1, 42'd7, 1, 0, 0, 4, 1, 42'd2, 1, 2);
        tbl[19] = mk(0, 0, '0, 1, 0, 0, 3, 1, 42'd3, 1, 2);
        tbl[20] = mk(0, 0, '0, 1, 0, 0, 2, 1, 42'd4, 1, 2);
        tbl[21] = mk(0, 0, '0, 1, 0, 0, 1, 1, 42'd7, 1, 2);
        tbl[22] = mk(0, 0, '0, 1, 0, 0, 0, 0, 42'd7, 1, 2);
        // flush with en, then clear
        tbl[23] = mk(0, 1, 42'h11, 0, 0, 0, 1, 1, 42'h11, 1, 2);
        tbl[24] = mk(0, 1, 42'h12, 0, 0, 0, 2, 1, 42'h11, 1, 2);
        tbl[25] = mk(0, 1, 42'h13, 0, 0, 0, 3, 1, 42'h11, 1, 2);
        tbl[26] = mk(0, 1, 42'h14, 0, 1, 0, 0, 0, 42'h11, 1, 2);
        tbl[27] = mk(0, 0, '0, 0, 0, 1, 0, 0, 42'h11, 0, 0);

        for (int i = 0; i < 28; i++) begin
            cycle(tbl[i].rst, tbl[i].en, tbl[i].din, tbl[i].rdy, tbl[i].fl, tbl[i].clr);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].cnt));
            chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'(tbl[i].vld));
            chk($sformatf("vec%0d_q", i), 64'(Q), 64'(tbl[i].q));
            chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'(tbl[i].ovf));
            chk($sformatf("vec%0d_drop", i), 64'(drop_cnt), 64'(tbl[i].drp));
        end

        // saturation of the drop counter
        for (int i = 0; i < 4; i++) cycle(0, 1, 42'h100 + 42'(i), 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 42'h200 + 42'(i), 0, 0, 0);
        chk("sat_drop_cnt", 64'(drop_cnt), 64'd3);
        chk("sat_ovf", 64'(ovf), 64'd1);

        // drop coinciding with clr_ovf
        cycle(0, 1, 42'h2FF, 0, 0, 1);
        chk("clr_drop_ovf", 64'(ovf), 64'd1);
        chk("clr_drop_cnt", 64'(drop_cnt), 64'd1);
        cycle(0, 0, '0, 0, 0, 1);
        chk("clr_cnt", 64'(drop_cnt), 64'd0);

        // streaming through a full buffer: pointers wrap, no drops
        for (int i = 0; i < 20; i++) cycle(0, 1, 42'h300 + 42'(i), 1, 0, 0);
        chk("stream_count", 64'(count), 64'd4);
        chk("stream_drop", 64'(drop_cnt), 64'd0);
        chk("stream_head", 64'(Q), 64'h310);
        for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 0, 0);
        chk("stream_empty", 64'(empty), 64'd1);
        cycle(0, 0, '0, 1, 0, 0);

        // reset mid-stream with en high
        for (int i = 0; i < 3; i++) cycle(0, 1, 42'h400 + 42'(i), 0, 0, 0);
        cycle(0, 1, 42'h4AA, 0, 0, 0);
        cycle(0, 1, 42'h4AB, 0, 0, 0);
        cycle(1, 1, 42'h4FF, 0, 0, 0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_q", 64'(Q), 64'd0);
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        cycle(0, 0, '0, 1, 0, 0);
        chk("rst_not_captured", 64'(rd_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
